// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-port RAM.
// Optional power-up RAM wipe is built in when RAM_ARB_CLEAR_EN is defined.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  busy
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitrates on each edge
  // ACCESS | RAM driven with the winner's latched address/data/we
  // RESP   | done/out pulsed to the winner for one cycle
  // CLEAR  | post-reset wipe walking every RAM address (optional)
`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t                state;
  logic                  win;
  logic                  last;
  logic                  pick1;
  logic [DATA_WIDTH-1:0] rdata;

  // last = 1 means requester 1 was served last, so requester 0 wins a tie
  assign pick1 = req1 & (~req0 | ~last);
  // the RAM output registers hold the latched transaction during ACCESS
  assign rdata = ram_load ? ram_in : ram_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      win      <= 1'b0;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      out0     <= '0;
      out1     <= '0;
      ram_addr <= '0;
      ram_in   <= '0;
`ifdef RAM_ARB_CLEAR_EN
      state    <= CLEAR;
      busy     <= 1'b1;
      ram_load <= 1'b1;
`else
      state    <= IDLE;
      busy     <= 1'b0;
      ram_load <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            win      <= pick1;
            last     <= pick1;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            ram_addr <= pick1 ? addr1 : addr0;
            ram_in   <= pick1 ? in1 : in0;
            ram_load <= pick1 ? we1 : we0;
          end
        end
        ACCESS: begin
          state    <= RESP;
          done0    <= ~win;
          done1    <= win;
          out0     <= win ? '0 : rdata;
          out1     <= win ? rdata : '0;
          ram_addr <= '0;
          ram_in   <= '0;
          ram_load <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          out0  <= '0;
          out1  <= '0;
        end
`ifdef RAM_ARB_CLEAR_EN
        CLEAR: begin
          if (ram_addr == '1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ram_load <= 1'b0;
            ram_addr <= '0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM; covers the
// RAM_ARB_CLEAR_EN wipe when that macro is defined.
module tb_ram_arbiter;
`ifdef RAM_ARB_CLEAR_EN
  localparam int AW = 3;
  localparam bit CLR = 1'b1;
`else
  localparam int AW = 6;
  localparam bit CLR = 1'b0;
`endif
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] in0 = '0, in1 = '0;
  logic          gnt0, gnt1, done0, done1, ram_load, busy;
  logic [DW-1:0] out0, out1, ram_in, ram_out;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init = 1'b1;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 16'hDEAD;
    end else if (ram_load) begin
      mem[ram_addr] <= ram_in;
    end
  end
  assign ram_out = mem[ram_addr];

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .in0(in0), .in1(in1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .out0(out0), .out1(out1),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load),
    .ram_out(ram_out), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    mem_init = 1'b0;
    tick();
    tests++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
      fails++; $display("FAIL reset_gnt_done: got %b want 0000", {gnt0, gnt1, done0, done1});
    end
    tests++;
    if (out0 !== '0 || out1 !== '0) begin
      fails++; $display("FAIL reset_out: got %h/%h want 0/0", out0, out1);
    end
    tests++;
    if (busy !== CLR || ram_load !== CLR || ram_addr !== '0) begin
      fails++; $display("FAIL reset_busy_load: got busy=%b load=%b addr=%0d want %b/%b/0",
                        busy, ram_load, ram_addr, CLR, CLR);
    end
    reset = 1'b0;
  endtask

`ifdef RAM_ARB_CLEAR_EN
  task automatic test_clear();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (ram_load !== 1'b1 || ram_addr !== AW'(i) || ram_in !== '0 || busy !== 1'b1) begin
        fails++; $display("FAIL clear_walk[%0d]: got load=%b addr=%0d in=%h busy=%b want 1/%0d/0/1",
                          i, ram_load, ram_addr, ram_in, busy, i);
      end
      if (i == 3) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd6;
      end
      tick();
    end
    tests++;
    if (busy !== 1'b0 || ram_load !== 1'b0 || gnt0 !== 1'b0) begin
      fails++; $display("FAIL clear_end: got busy=%b load=%b gnt0=%b want 0/0/0", busy, ram_load, gnt0);
    end
    tick();
    tests++;
    if (gnt0 !== 1'b1 || ram_addr !== 3'd6) begin
      fails++; $display("FAIL clear_serve: got gnt0=%b addr=%0d want 1/6", gnt0, ram_addr);
    end
    tick();
    tests++;
    if (done0 !== 1'b1 || out0 !== 16'h0000) begin
      fails++; $display("FAIL clear_read6: got done0=%b out0=%h want 1/0000", done0, out0);
    end
    req0 = 1'b0;
    tick();
  endtask
`endif

  task automatic test_write();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(5); in0 = 16'h00AB;
    tick();
    tests++;
    if (ram_load !== 1'b1 || ram_addr !== AW'(5) || ram_in !== 16'h00AB || gnt0 !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL write_access: got load=%b addr=%0d in=%h gnt0=%b busy=%b want 1/5/00ab/1/1",
                        ram_load, ram_addr, ram_in, gnt0, busy);
    end
    tick();
    tests++;
    if (done0 !== 1'b1 || out0 !== 16'h00AB || done1 !== 1'b0 || out1 !== '0 || ram_load !== 1'b0) begin
      fails++; $display("FAIL write_resp: got done0=%b out0=%h done1=%b out1=%h load=%b want 1/00ab/0/0/0",
                        done0, out0, done1, out1, ram_load);
    end
    req0 = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || done0 !== 1'b0 || out0 !== '0 || mem[5] !== 16'h00AB) begin
      fails++; $display("FAIL write_idle: got busy=%b done0=%b out0=%h mem5=%h want 0/0/0/00ab",
                        busy, done0, out0, mem[5]);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(5); in1 = 16'hFFFF;
    tick();
    tests++;
    if (ram_load !== 1'b0 || ram_addr !== AW'(5) || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      fails++; $display("FAIL read_access: got load=%b addr=%0d gnt1=%b gnt0=%b want 0/5/1/0",
                        ram_load, ram_addr, gnt1, gnt0);
    end
    addr1 = AW'(2);
    we1 = 1'b1;
    tick();
    tests++;
    if (done1 !== 1'b1 || out1 !== 16'h00AB || done0 !== 1'b0 || out0 !== '0) begin
      fails++; $display("FAIL read_resp: got done1=%b out1=%h done0=%b out0=%h want 1/00ab/0/0",
                        done1, out1, done0, out0);
    end
    req1 = 1'b0; we1 = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int prev;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(2); in0 = 16'h1234;
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(5);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!(done0 | done1) && n < 10) begin
        tick();
        n++;
      end
      tests++;
      if (n >= 10) begin
        fails++; $display("FAIL rr_timeout[%0d]: got no done want done within 10 cycles", k);
      end else begin
        if (done0 !== (k % 2 == 0) || done1 !== (k % 2 == 1) ||
            out0 !== ((k % 2 == 0) ? 16'h1234 : 16'h0000) ||
            out1 !== ((k % 2 == 1) ? 16'h00AB : 16'h0000)) begin
          fails++; $display("FAIL rr_order[%0d]: got done=%b%b out0=%h out1=%h want requester %0d",
                            k, done0, done1, out0, out1, k % 2);
        end
        if (k > 0) begin
          tests++;
          if (cyc - prev !== 3) begin
            fails++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", k, cyc - prev);
          end
        end
        prev = cyc;
      end
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rr_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(7); in0 = 16'h5555;
    tick();
    tests++;
    if (ram_load !== 1'b1 || gnt0 !== 1'b1) begin
      fails++; $display("FAIL abort_pre: got load=%b gnt0=%b want 1/1", ram_load, gnt0);
    end
    reset = 1'b1;
    req0 = 1'b0;
    tick();
    tests++;
    if (done0 !== 1'b0 || gnt0 !== 1'b0 || busy !== CLR || ram_load !== CLR) begin
      fails++; $display("FAIL abort_post: got done0=%b gnt0=%b busy=%b load=%b want 0/0/%b/%b",
                        done0, gnt0, busy, ram_load, CLR, CLR);
    end
    reset = 1'b0;
    if (CLR) repeat (8) @(posedge clk);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(5);
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(2);
    tick();
    tests++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      fails++; $display("FAIL abort_tie: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1);
    end
    tick();
    tests++;
    if (done0 !== 1'b1 || out0 !== (CLR ? 16'h0000 : 16'h00AB)) begin
      fails++; $display("FAIL abort_read: got done0=%b out0=%h want 1/%h",
                        done0, out0, CLR ? 16'h0000 : 16'h00AB);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
`ifdef RAM_ARB_CLEAR_EN
    test_clear();
`endif
    test_write();
    test_read();
    test_round_robin();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 6: RAM address width (64 words).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 REQ0/REQ1  input  1  requester n access request, held high until its DONEn.
REQ-006 WE0/WE1  input  1  requester n write enable (1 = write, 0 = read).
REQ-007 ADDR0/ADDR1  input  ADDR_WIDTH  requester n word address.
REQ-008 IN0/IN1  input  DATA_WIDTH  requester n write data.
REQ-009 GNT0/GNT1  output  1  requester n owns the RAM.
REQ-010 DONE0/DONE1  output  1  one-cycle completion strobe for requester n.
REQ-011 OUT0/OUT1  output  DATA_WIDTH  requester n response data, valid while DONEn is high.
REQ-012 RAM_ADDR  output  ADDR_WIDTH  address to the shared single-port RAM.
REQ-013 RAM_IN  output  DATA_WIDTH  write data to the RAM.
REQ-014 RAM_LOAD  output  1  RAM write strobe; the RAM writes RAM_IN at the next CLK edge.
REQ-015 RAM_OUT  input  DATA_WIDTH  combinational RAM read data for RAM_ADDR.
REQ-016 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, ACCESS, RESP, plus CLEAR when RAM_ARB_CLEAR_EN is defined.
REQ-018 IDLE: at an edge with any REQ high, latch the winner's WE, ADDR and IN, record the winner, then go to ACCESS.
REQ-019 Arbitration is round-robin: on a tie, the requester not served last wins; a single requester always wins.
REQ-020 ACCESS (one cycle): drive RAM_ADDR and RAM_IN from the latched values and RAM_LOAD = latched WE.
REQ-021 On the edge ending ACCESS, capture RAM_OUT for reads or the latched write data for writes into the response register, then go to RESP.
REQ-022 RESP (one cycle): DONEn = 1 and OUTn = response register for the winner only, then go to IDLE.
REQ-023 GNTn is high in ACCESS and RESP for the winner only.
REQ-024 Latency: REQ sampled at edge t gives ACCESS in cycle t+1 and DONE in cycle t+2; peak throughput is one transaction per 3 cycles.
REQ-025 Request inputs are ignored outside IDLE; changes during ACCESS or RESP have no effect on the transaction in progress.
REQ-026 A requester that keeps REQ high after its DONE is re-arbitrated in IDLE and loses any tie to the other requester.
REQ-027 Outside ACCESS and CLEAR: RAM_LOAD = 0, RAM_ADDR = 0, RAM_IN = 0.
REQ-028 Inactive-requester OUTn = 0; DONEn and GNTn are never high for both requesters at once.

Reset
REQ-029 When RESET is high at an edge: state goes to IDLE (or CLEAR when enabled), the last-served pointer is set to 1 (requester 0 wins the first tie), and the latched and response registers are cleared to 0.
REQ-030 Reset values: all GNT, DONE and OUT = 0, RAM_LOAD = 0, BUSY = 0 (1 if CLEAR is enabled).
REQ-031 Reset mid-ACCESS or mid-RESP aborts the transaction: no DONE pulse, RAM_LOAD low in the following cycle.

Configuration
REQ-032 Macro RAM_ARB_CLEAR_EN.
- Defined: after reset, the CLEAR state walks RAM_ADDR from 0 to 2^ADDR_WIDTH-1, one address per cycle, with RAM_LOAD = 1 and RAM_IN = 0.
- Defined: on the cycle after the last address, the state goes to IDLE; requests are ignored during CLEAR; BUSY = 1 throughout.
- Defined: reset during CLEAR restarts the walk at address 0.
REQ-033 Macro not defined: no CLEAR state exists, and reset goes directly to IDLE.

Verification
REQ-034 REQ0=1, WE0=1, ADDR0=5, IN0=0x00AB -> RAM_LOAD=1 with RAM_ADDR=5 in cycle t+1; DONE0 with OUT0=0x00AB in cycle t+2.
REQ-035 Subsequent REQ1=1, WE1=0, ADDR1=5 -> DONE1 with OUT1=0x00AB; RAM_LOAD stays 0.
REQ-036 REQ0 and REQ1 both held high for 4 transactions -> grant order 0,1,0,1; DONE pulses 3 cycles apart.
REQ-037 RESET asserted during ACCESS of a write -> no DONE pulse, BUSY=0 next cycle, and the next tie goes to requester 0.
REQ-038 With RAM_ARB_CLEAR_EN, ADDR_WIDTH=3: after reset, 8 cycles of RAM_LOAD=1 with RAM_ADDR 0..7; a REQ0 raised during CLEAR is served immediately after; a read of address 6 returns 0.
